mdom_wvb_hdr_bundle_4_builder: RTL and testbench

Packs per-waveform header fields into the 106-bit mDOM waveform-buffer header bundle (bundle format 4) and writes one bundle per captured waveform into the header FIFO. Sits in each channel's waveform buffer, between the trigger/address logic and the header FIFO. The existing fan-out block unpacks these bundles on the readout side. Provides start/stop capture, address and LTC pre-trigger correction, one-deep holding under FIFO backpressure, and drop reporting.

---
 rtl/mdom_wvb_hdr_bundle_4_builder_if.sv | 12 +
 rtl/mdom_wvb_hdr_bundle_4_builder.sv | 138 +++++++++++++
 tb/tb_mdom_wvb_hdr_bundle_4_builder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mdom_wvb_hdr_bundle_4_builder_if.sv
// Header FIFO write port carrying format-4 waveform header bundles.
// The builder drives the master side and the FIFO is the slave side.
interface mdom_wvb_hdr_bundle_4_builder_if #(
  parameter int HDR_W = 106
);
  logic             hdr_wr;
  logic [HDR_W-1:0] hdr_data;
  logic             hdr_full;

  modport master (output hdr_wr, output hdr_data, input hdr_full);
  modport slave  (input hdr_wr, input hdr_data, output hdr_full);
endinterface

// File: rtl/mdom_wvb_hdr_bundle_4_builder.sv
// Builds one 106-bit format-4 header bundle per captured waveform and writes it
// into the header FIFO, holding one finished bundle while the FIFO is full.
module mdom_wvb_hdr_bundle_4_builder #(
  parameter int P_ADR_W = 12,
  parameter int P_LTC_W = 49
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [P_LTC_W-1:0]   ltc,
  input  logic                 trig_start,
  input  logic [P_ADR_W-1:0]   trig_addr,
  input  logic [1:0]           trig_src,
  input  logic                 cnst_run,
  input  logic                 local_coinc,
  input  logic [4:0]           pre_conf,
  input  logic                 sync_rdy,
  input  logic [18:0]          bsum,
  input  logic [2:0]           bsum_len_sel,
  input  logic                 bsum_valid,
  input  logic                 trig_stop,
  input  logic [P_ADR_W-1:0]   stop_addr,
  mdom_wvb_hdr_bundle_4_builder_if.master hdr,
  output logic                 busy,
  output logic                 drop
);
  localparam int HDR_W   = 2 * P_ADR_W + P_LTC_W + 33;
  localparam int STOP_LO = P_ADR_W + P_LTC_W;
  localparam int STOP_HI = 2 * P_ADR_W + P_LTC_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_PENDING = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic               latch_start_s;
  logic               latch_stop_s;
  logic               drop_s;
  logic               hdr_wr_s;
  logic               start_ok_s;
  logic [P_ADR_W-1:0] start_addr_s;
  logic [P_LTC_W-1:0] evt_ltc_s;
  logic [HDR_W-1:0]   hdr_data_r;
  logic               drop_r;

  assign start_ok_s   = trig_start & en;
  // Pre-trigger correction wraps modulo the buffer depth and the LTC range.
  assign start_addr_s = trig_addr - {{(P_ADR_W-5){1'b0}}, pre_conf};
  assign evt_ltc_s    = ltc - {{(P_LTC_W-5){1'b0}}, pre_conf};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state, latch enables, drop request and FIFO write strobe.
  always_comb begin
    state_s       = state_r;
    latch_start_s = 1'b0;
    latch_stop_s  = 1'b0;
    drop_s        = 1'b0;
    hdr_wr_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          latch_start_s = 1'b1;
          state_s       = ST_CAPTURE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        // Disable wins over a same-cycle stop; the partial event is discarded.
        if (!en) begin
          state_s = ST_IDLE;
        end else if (trig_stop) begin
          latch_stop_s = 1'b1;
          drop_s       = trig_start;
          state_s      = ST_PENDING;
        end else begin
          drop_s  = trig_start;
          state_s = ST_CAPTURE;
        end
      end
      ST_PENDING: begin
        if (!hdr.hdr_full) begin
          hdr_wr_s = 1'b1;
          if (start_ok_s) begin
            latch_start_s = 1'b1;
            state_s       = ST_CAPTURE;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          drop_s  = start_ok_s;
          state_s = ST_PENDING;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bundle register; the write of a pending bundle and a new start latch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_data_r <= {HDR_W{1'b0}};
    end else if (latch_start_s) begin
      hdr_data_r <= {local_coinc, bsum_valid, bsum_len_sel, bsum, sync_rdy,
                     pre_conf, cnst_run, trig_src, hdr_data_r[STOP_HI:STOP_LO],
                     start_addr_s, evt_ltc_s};
    end else if (latch_stop_s) begin
      hdr_data_r[STOP_HI:STOP_LO] <= stop_addr;
    end
  end

  // Registered drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_r <= 1'b0;
    end else begin
      drop_r <= drop_s;
    end
  end

  assign hdr.hdr_wr   = hdr_wr_s;
  assign hdr.hdr_data = hdr_data_r;
  assign busy         = (state_r != ST_IDLE);
  assign drop         = drop_r;
endmodule

// File: tb/tb_mdom_wvb_hdr_bundle_4_builder.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against an event-level reference model of the header builder.
module tb_mdom_wvb_hdr_bundle_4_builder;
  logic        clk = 1'b0;
  logic        rst, en, trig_start, trig_stop, cnst_run, local_coinc, sync_rdy, bsum_valid;
  logic [48:0] ltc;
  logic [11:0] trig_addr, stop_addr;
  logic [1:0]  trig_src;
  logic [4:0]  pre_conf;
  logic [18:0] bsum;
  logic [2:0]  bsum_len_sel;
  logic        busy, drop;

  mdom_wvb_hdr_bundle_4_builder_if #(.HDR_W(106)) hdr ();

  mdom_wvb_hdr_bundle_4_builder dut (
    .clk(clk), .rst(rst), .en(en), .ltc(ltc), .trig_start(trig_start),
    .trig_addr(trig_addr), .trig_src(trig_src), .cnst_run(cnst_run),
    .local_coinc(local_coinc), .pre_conf(pre_conf), .sync_rdy(sync_rdy),
    .bsum(bsum), .bsum_len_sel(bsum_len_sel), .bsum_valid(bsum_valid),
    .trig_stop(trig_stop), .stop_addr(stop_addr), .hdr(hdr),
    .busy(busy), .drop(drop)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_wr   = 0;
  int n_drop = 0;

  // Event-level model: is an event open, has it been closed, what bundle is held.
  bit           m_open = 1'b0;
  bit           m_closed = 1'b0;
  bit           m_drop = 1'b0;
  logic [105:0] m_data = '0;

  task automatic check_val(input string tag, input logic [105:0] got, input logic [105:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [105:0] start_bundle(input logic [105:0] old);
    logic [48:0] ev;
    logic [11:0] sa;
    ev = ltc - {44'd0, pre_conf};
    sa = trig_addr - {7'd0, pre_conf};
    return {local_coinc, bsum_valid, bsum_len_sel, bsum, sync_rdy, pre_conf,
            cnst_run, trig_src, old[72:61], sa, ev};
  endfunction

  task automatic model_edge();
    bit accept;
    bit nd;
    accept = trig_start && en;
    nd = 1'b0;
    if (rst) begin
      m_open = 1'b0; m_closed = 1'b0; m_data = '0;
    end else if (!m_open) begin
      if (accept) begin
        m_data = start_bundle(m_data); m_open = 1'b1; m_closed = 1'b0;
      end
    end else if (!m_closed) begin
      if (!en) begin
        m_open = 1'b0;
      end else begin
        if (trig_stop) begin
          m_data[72:61] = stop_addr; m_closed = 1'b1;
        end
        nd = trig_start;
      end
    end else if (!hdr.hdr_full) begin
      if (accept) begin
        m_data = start_bundle(m_data); m_closed = 1'b0;
      end else begin
        m_open = 1'b0; m_closed = 1'b0;
      end
    end else begin
      nd = accept;
    end
    m_drop = nd;
  endtask

  // One clock: compare outputs mid-cycle, advance the model, then pass the edge.
  task automatic cycle();
    bit exp_wr;
    @(negedge clk);
    exp_wr = m_open && m_closed && !hdr.hdr_full;
    check_val("hdr_wr", {105'd0, hdr.hdr_wr}, {105'd0, exp_wr});
    check_val("busy",   {105'd0, busy},       {105'd0, m_open});
    check_val("drop",   {105'd0, drop},       {105'd0, m_drop});
    check_val("hdr_data", hdr.hdr_data, m_data);
    if (hdr.hdr_wr === 1'b1) n_wr++;
    if (drop === 1'b1) n_drop++;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic quiet();
    rst = 1'b0; en = 1'b1; trig_start = 1'b0; trig_stop = 1'b0; hdr.hdr_full = 1'b0;
  endtask

  task automatic set_fields(input logic [48:0] l, input logic [11:0] a, input logic [4:0] p);
    ltc = l; trig_addr = a; pre_conf = p;
    trig_src = 2'($urandom); cnst_run = 1'($urandom); local_coinc = 1'($urandom);
    sync_rdy = 1'($urandom); bsum = 19'($urandom); bsum_len_sel = 3'($urandom);
    bsum_valid = 1'($urandom);
  endtask

  task automatic pulse_start();
    trig_start = 1'b1; cycle(); trig_start = 1'b0;
  endtask

  task automatic pulse_stop(input logic [11:0] sa);
    stop_addr = sa; trig_stop = 1'b1; cycle(); trig_stop = 1'b0;
  endtask

  int w0, d0;
  logic [48:0] first_ltc;

  initial begin
    quiet();
    set_fields(49'd0, 12'd0, 5'd0);
    stop_addr = 12'd0;
    rst = 1'b1;
    cycles(2);
    check_val("rst_busy", {105'd0, busy}, 106'd0);
    check_val("rst_data", hdr.hdr_data, 106'd0);
    rst = 1'b0;
    cycles(2);

    // Basic capture with fixed expected fields.
    set_fields(49'h1000, 12'h010, 5'd5);
    trig_src = 2'd2; bsum = 19'h12345;
    w0 = n_wr;
    pulse_start();
    cycles(19);
    pulse_stop(12'h024);
    check_val("basic_no_early_wr", 106'(n_wr - w0), 106'd0);
    cycle();
    check_val("basic_wr_count", 106'(n_wr - w0), 106'd1);
    check_val("basic_evt_ltc", {57'd0, hdr.hdr_data[48:0]}, 106'hFFB);
    check_val("basic_start", {94'd0, hdr.hdr_data[60:49]}, 106'h00B);
    check_val("basic_stop", {94'd0, hdr.hdr_data[72:61]}, 106'h024);
    check_val("basic_src", {104'd0, hdr.hdr_data[74:73]}, 106'd2);
    check_val("basic_bsum", {87'd0, hdr.hdr_data[100:82]}, 106'h12345);
    cycles(2);

    // Wrap-around of both subtractions.
    set_fields(49'd3, 12'h002, 5'd7);
    pulse_start();
    check_val("wrap_start", {94'd0, hdr.hdr_data[60:49]}, 106'hFFB);
    check_val("wrap_ltc", {57'd0, hdr.hdr_data[48:0]}, 106'h1_FFFF_FFFF_FFFC);
    cycles(3);
    pulse_stop(12'h010);
    cycles(2);

    // Backpressure: hold under full, drop a start, write the first event.
    set_fields(49'h0_ABCD_1234_5678, 12'h300, 5'd9);
    first_ltc = 49'h0_ABCD_1234_5678 - 49'd9;
    pulse_start();
    cycles(4);
    w0 = n_wr; d0 = n_drop;
    hdr.hdr_full = 1'b1;
    pulse_stop(12'h350);
    cycles(4);
    set_fields(49'h77, 12'h123, 5'd1);
    pulse_start();
    cycles(5);
    check_val("bp_no_wr_full", 106'(n_wr - w0), 106'd0);
    hdr.hdr_full = 1'b0;
    cycles(3);
    check_val("bp_wr_count", 106'(n_wr - w0), 106'd1);
    check_val("bp_drop_count", 106'(n_drop - d0), 106'd1);
    check_val("bp_first_ltc", {57'd0, hdr.hdr_data[48:0]}, {57'd0, first_ltc});

    // Back-to-back: new start in the write cycle.
    w0 = n_wr; d0 = n_drop;
    set_fields(49'h500, 12'h040, 5'd2);
    pulse_start();
    cycles(2);
    pulse_stop(12'h060);
    set_fields(49'h900, 12'h080, 5'd3);
    pulse_start();
    cycles(2);
    pulse_stop(12'h0A0);
    cycles(2);
    check_val("b2b_wr_count", 106'(n_wr - w0), 106'd2);
    check_val("b2b_drop_count", 106'(n_drop - d0), 106'd0);

    // Abort by disable mid-capture.
    w0 = n_wr;
    set_fields(49'h1234, 12'h100, 5'd4);
    pulse_start();
    cycles(3);
    en = 1'b0; stop_addr = 12'h111; trig_stop = 1'b1;
    cycle();
    trig_stop = 1'b0; en = 1'b1;
    check_val("abort_busy", {105'd0, busy}, 106'd0);
    cycles(3);
    check_val("abort_no_wr", 106'(n_wr - w0), 106'd0);

    // Reset while pending.
    set_fields(49'h4321, 12'h200, 5'd6);
    pulse_start();
    hdr.hdr_full = 1'b1;
    pulse_stop(12'h222);
    cycles(2);
    rst = 1'b1;
    cycle();
    rst = 1'b0; hdr.hdr_full = 1'b0;
    check_val("rstp_data", hdr.hdr_data, 106'd0);
    cycles(3);
    check_val("rstp_no_wr", 106'(n_wr - w0), 106'd0);

    // Ignored stop in idle, second start in capture.
    pulse_stop(12'h333);
    check_val("idle_stop_busy", {105'd0, busy}, 106'd0);
    d0 = n_drop;
    set_fields(49'h2222, 12'h400, 5'd8);
    first_ltc = 49'h2222 - 49'd8;
    pulse_start();
    set_fields(49'h9999, 12'h777, 5'd1);
    pulse_start();
    cycles(2);
    pulse_stop(12'h420);
    cycle();
    check_val("ign_drop", 106'(n_drop - d0), 106'd1);
    check_val("ign_first_ltc", {57'd0, hdr.hdr_data[48:0]}, {57'd0, first_ltc});

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      set_fields(49'({$urandom(), $urandom()}), 12'($urandom), 5'($urandom));
      stop_addr     = 12'($urandom);
      trig_start    = ($urandom_range(0, 5) == 0);
      trig_stop     = ($urandom_range(0, 5) == 0);
      en            = ($urandom_range(0, 19) != 0);
      hdr.hdr_full  = ($urandom_range(0, 2) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
